pll_clk_manager: RTL and testbench
==================================

Name: pll_clk_manager

Overview:
- Sits directly downstream of the vendor PLL wrapper and is the single owner of "PLL is usable" state for the SoC.
- Synchronises and filters the raw PLL lock signal.
- Releases per-domain resets in a staggered sequence, then generates NUM_CH independent glitch-free clock-enable streams from the PLL output clock.
- Detects loss of lock at runtime: re-asserts all resets and counts the events.

Parameters:
- NUM_CH, 2, number of clock-enable/reset channels (1..8)
- DIV_W, 8, width of each channel's divider value
- LOCK_FILTER, 16, consecutive synchronised-high lock cycles required before release (>=1)
- RST_STAGGER, 4, cycles between successive channel reset releases (>=1)
- TIMEOUT, 65535, lock watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  PLL output clock; all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- pll_lock_i  in  1  raw PLL lock, asynchronous to clk
- div_i  in  NUM_CH*DIV_W  per-channel divide value, channel k at bits [k*DIV_W +: DIV_W]
- div_load_i  in  1  one-cycle strobe: capture div_i into the shadow registers
- ce_o  out  NUM_CH  per-channel clock-enable pulses
- rst_n_o  out  NUM_CH  per-channel synchronous active-low domain resets
- locked_o  out  1  high in RUN
- lock_lost_o  out  1  one-cycle pulse on loss of lock
- lost_cnt_o  out  8  saturating lock-loss counter
- timeout_o  out  1  present only with LOCK_TIMEOUT_EN

Behaviour:
- Reset values (resetn low): all outputs 0; FSM in WAIT_LOCK; shadow and active dividers 0; phase counters 0.
- Lock synchroniser:
  - 2-flop synchroniser produces lock_s.
  - Lock edges reach the FSM 2 cycles after pll_lock_i changes.
- FSM states and transitions:
  - WAIT_LOCK: filt_cnt=0. On lock_s=1, go to FILTER.
  - FILTER:
    - filt_cnt increments each cycle lock_s=1.
    - lock_s=0 → WAIT_LOCK; no pulse, no count.
    - When filt_cnt reaches LOCK_FILTER-1 with lock_s=1 → RELEASE, seq_cnt=0.
  - RELEASE:
    - seq_cnt increments each cycle.
    - rst_n_o[k] rises on the cycle seq_cnt == k*RST_STAGGER, and stays high.
    - The cycle after the last channel is released → RUN.
  - RUN: locked_o=1.
  - Loss of lock: lock_s=0 in RELEASE or RUN triggers, on the next edge:
    - all rst_n_o=0 and locked_o=0;
    - lock_lost_o=1 for exactly one cycle;
    - lost_cnt_o increments, saturating at 255;
    - FSM → WAIT_LOCK.
  - Loss of lock in the same cycle as the final release: loss wins.
- Dividers:
  - Each channel has a shadow register and an active register, both DIV_W wide.
  - div_load_i writes all shadow registers.
  - A channel's active register copies its shadow only when that channel's phase counter wraps, or while its rst_n_o=0. This makes divider changes glitch-free.
- Clock-enable generation:
  - While rst_n_o[k]=0: phase counter held at 0, ce_o[k]=0.
  - Otherwise: ce_o[k]=1 on the cycle phase == active div, and phase then wraps to 0; else phase increments.
  - Result: div=0 gives ce every cycle; div=N gives period N+1.
  - The first ce after release arrives div+1 cycles after rst_n_o[k] rises.
- div_load_i coincident with a wrap: the old active value governs the wrapping cycle; the new value governs the next period.
- resetn asserted mid-sequence: asynchronous return to reset values immediately. lost_cnt_o is also cleared.

Optional Feature:
- Macro: PLL_CLK_MANAGER_LOCK_TIMEOUT_EN.
- Defined:
  - timeout_o port exists.
  - A 16-bit watchdog counts cycles spent in WAIT_LOCK/FILTER since reset or since the last loss.
  - Reaching TIMEOUT sets timeout_o sticky-high.
  - timeout_o clears only when the FSM enters RUN, or on resetn.
- Undefined: no port, no counter; behaviour otherwise identical.

Decomposition:
- Shared package pll_clk_pkg holds:
  - the FSM state enum (WAIT_LOCK, FILTER, RELEASE, RUN);
  - LOST_CNT_W=8;
  - the default LOCK_FILTER and RST_STAGGER constants.
- One sub-module, clk_en_div: a single channel's shadow/active divider, phase counter and ce output. It is instantiated NUM_CH times by generate.

Test Plan:
- Power-up: resetn low 5 cycles, lock held high; NUM_CH=2, LOCK_FILTER=16, RST_STAGGER=4. Required: rst_n_o[0] rises at cycle 2+16+1 after resetn release, rst_n_o[1] 4 cycles later, locked_o 1 cycle after that.
- Filter glitch: lock high 10 cycles, low 1 cycle, then high. Required: no release until 16 further consecutive high cycles; lock_lost_o never pulses; lost_cnt_o=0.
- Divide: div_i={8'd3,8'd0} loaded before lock. Required: in RUN, ce_o[0] every cycle; ce_o[1] every 4th cycle, first pulse 4 cycles after rst_n_o[1] rises.
- Runtime divider change: in RUN change ch1 from 3 to 1 mid-period. Required: current 4-cycle period completes, then period 2, with no short or double pulse.
- Loss of lock: drop lock in RUN. Required: 3 cycles later all rst_n_o=0, locked_o=0, one-cycle lock_lost_o, lost_cnt_o=1. 256 losses → lost_cnt_o=255.
- Timeout (macro defined, TIMEOUT=100): lock never asserted. Required: timeout_o=1 at cycle 100, held; then lock → timeout_o clears on entry to RUN.

Source files
------------

// File: rtl/pll_clk_pkg.sv
// Shared types and constants for the PLL clock manager: FSM states, counter
// widths and default lock-filter / reset-stagger settings.
package pll_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int LOST_CNT_W      = 8;
  localparam int DEF_LOCK_FILTER = 16;
  localparam int DEF_RST_STAGGER = 4;

endpackage

// File: rtl/clk_en_div.sv
// One clock-enable channel: shadow/active divider pair, phase counter and a
// registered ce pulse every (active+1) cycles while the channel is out of reset.
module clk_en_div
  import pll_clk_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rst_n_ch,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             ce_o
);

  logic [DIV_W-1:0] shadow_q;
  logic [DIV_W-1:0] shadow_d;
  logic [DIV_W-1:0] active_q;
  logic [DIV_W-1:0] phase_q;
  logic             ce_q;
  logic             wrap;

  // Forward a same-cycle load so a load coincident with a wrap governs the next period.
  assign shadow_d = div_load_i ? div_i : shadow_q;
  assign wrap     = rst_n_ch && (phase_q == active_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_q <= '0;
      active_q <= '0;
      phase_q  <= '0;
      ce_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (!rst_n_ch || wrap) begin
        active_q <= shadow_d;
      end
      if (!rst_n_ch || wrap) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_q + DIV_W'(1);
      end
      ce_q <= wrap;
    end
  end

  // Masking with the channel reset keeps ce low in the cycle its reset drops.
  assign ce_o = ce_q && rst_n_ch;

endmodule

// File: rtl/pll_clk_manager.sv
// PLL lock filter, staggered per-domain reset release and per-channel clock enables.
// Optional lock watchdog output timeout_o is built when PLL_CLK_MANAGER_LOCK_TIMEOUT_EN is defined.
module pll_clk_manager
  import pll_clk_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int RST_STAGGER = DEF_RST_STAGGER,
  parameter int TIMEOUT     = 65535
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    pll_lock_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic                    div_load_i,
  output logic [NUM_CH-1:0]       ce_o,
  output logic [NUM_CH-1:0]       rst_n_o,
  output logic                    locked_o,
  output logic                    lock_lost_o,
  output logic [LOST_CNT_W-1:0]   lost_cnt_o
`ifdef PLL_CLK_MANAGER_LOCK_TIMEOUT_EN
  ,
  output logic                    timeout_o
`endif
);

  localparam int FILT_W   = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int LAST_SEQ_I = (NUM_CH - 1) * RST_STAGGER;
  localparam int SEQ_W    = (LAST_SEQ_I > 0) ? $clog2(LAST_SEQ_I + 1) : 1;
  localparam logic [FILT_W-1:0] LAST_FILT = FILT_W'(LOCK_FILTER - 1);
  localparam logic [SEQ_W-1:0]  LAST_SEQ  = SEQ_W'(LAST_SEQ_I);

  logic                  sync1_q;
  logic                  lock_s;
  pll_state_e            state_q, state_d;
  logic [FILT_W-1:0]     filt_q, filt_d;
  logic [SEQ_W-1:0]      seq_q, seq_d;
  logic [NUM_CH-1:0]     rst_q, rst_d;
  logic                  loss;
  logic                  locked_q;
  logic                  lost_q;
  logic [LOST_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync1_q <= pll_lock_i;
      lock_s  <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    seq_d   = seq_q;
    rst_d   = rst_q;
    loss    = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        filt_d = '0;
        if (lock_s) state_d = FILTER;
      end
      FILTER: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          filt_d  = '0;
        end else if (filt_q == LAST_FILT) begin
          state_d  = RELEASE;
          filt_d   = '0;
          seq_d    = '0;
          rst_d[0] = 1'b1;
        end else begin
          filt_d = filt_q + FILT_W'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          loss = 1'b1;
        end else if (seq_q == LAST_SEQ) begin
          state_d = RUN;
        end else begin
          seq_d = seq_q + SEQ_W'(1);
          for (int k = 1; k < NUM_CH; k++) begin
            if (seq_d == SEQ_W'(k * RST_STAGGER)) rst_d[k] = 1'b1;
          end
        end
      end
      RUN: begin
        if (!lock_s) loss = 1'b1;
      end
      default: state_d = WAIT_LOCK;
    endcase
    // Loss of lock overrides everything, including a final release this cycle.
    if (loss) begin
      state_d = WAIT_LOCK;
      rst_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= WAIT_LOCK;
      filt_q   <= '0;
      seq_q    <= '0;
      rst_q    <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      filt_q   <= filt_d;
      seq_q    <= seq_d;
      rst_q    <= rst_d;
      locked_q <= (state_d == RUN);
      lost_q   <= loss;
      if (loss && (cnt_q != '1)) cnt_q <= cnt_q + LOST_CNT_W'(1);
    end
  end

  assign rst_n_o     = rst_q;
  assign locked_o    = locked_q;
  assign lock_lost_o = lost_q;
  assign lost_cnt_o  = cnt_q;

`ifdef PLL_CLK_MANAGER_LOCK_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);
  logic [15:0] wd_q;
  logic        to_q;
  logic        waiting;

  assign waiting = (state_q == WAIT_LOCK) || (state_q == FILTER);

  // Watchdog runs only while hunting for lock; it restarts after each loss.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      if (loss) begin
        wd_q <= '0;
      end else if (waiting && (wd_q != TO_LIM)) begin
        wd_q <= wd_q + 16'd1;
      end
      if ((state_d == RUN) && (state_q != RUN)) begin
        to_q <= 1'b0;
      end else if (waiting && (wd_q != TO_LIM) && ((wd_q + 16'd1) == TO_LIM)) begin
        to_q <= 1'b1;
      end
    end
  end

  assign timeout_o = to_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_en_div #(.DIV_W(DIV_W)) u_div (
      .clk       (clk),
      .resetn    (resetn),
      .rst_n_ch  (rst_q[k]),
      .div_i     (div_i[k*DIV_W +: DIV_W]),
      .div_load_i(div_load_i),
      .ce_o      (ce_o[k])
    );
  end

endmodule

// File: tb/tb_pll_clk_manager.sv
// Self-checking bench for pll_clk_manager: directed power-up/divider/loss/reset
// steps plus a randomized lock-loss run, compared every cycle to an event-level model.
module tb_pll_clk_manager;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 8;
  localparam int LF     = 16;
  localparam int RS     = 4;
  localparam int TO     = 100;

  logic                    clk;
  logic                    resetn;
  logic                    pll_lock_i;
  logic [NUM_CH*DIV_W-1:0] div_i;
  logic                    div_load_i;
  logic [NUM_CH-1:0]       ce_o;
  logic [NUM_CH-1:0]       rst_n_o;
  logic                    locked_o;
  logic                    lock_lost_o;
  logic [7:0]              lost_cnt_o;
`ifdef PLL_CLK_MANAGER_LOCK_TIMEOUT_EN
  logic                    timeout_o;
`endif

  pll_clk_manager #(
    .NUM_CH     (NUM_CH),
    .DIV_W      (DIV_W),
    .LOCK_FILTER(LF),
    .RST_STAGGER(RS),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pll_lock_i (pll_lock_i),
    .div_i      (div_i),
    .div_load_i (div_load_i),
    .ce_o       (ce_o),
    .rst_n_o    (rst_n_o),
    .locked_o   (locked_o),
    .lock_lost_o(lock_lost_o),
    .lost_cnt_o (lost_cnt_o)
`ifdef PLL_CLK_MANAGER_LOCK_TIMEOUT_EN
    ,
    .timeout_o  (timeout_o)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  int n_pass;
  int n_total;

  // Reference model: lock seen by the FSM is the raw lock two edges old; a run of
  // LF+1 seen-high edges starts the release; everything else is timed from there.
  bit                lock_pipe[$];
  bit                m_active;
  int                m_streak;
  int                m_t;
  int                m_cnt;
  int                m_wd;
  int                edge_no;
  bit                m_lost;
  bit                m_locked;
  bit                m_to;
  logic [NUM_CH-1:0] m_rst;
  logic [NUM_CH-1:0] m_ce;
  int                m_shadow[NUM_CH];
  int                m_next_ce[NUM_CH];
  int                rise0, rise1, rise_lk, rise_ce1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    lock_pipe.delete();
    m_active = 1'b0;
    m_streak = 0;
    m_t      = 0;
    m_cnt    = 0;
    m_wd     = 0;
    edge_no  = 0;
    m_lost   = 1'b0;
    m_locked = 1'b0;
    m_to     = 1'b0;
    m_rst    = '0;
    m_ce     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_shadow[k]  = 0;
      m_next_ce[k] = 0;
    end
  endtask

  task automatic model_edge(input bit lk, input bit ld, input logic [NUM_CH*DIV_W-1:0] dv);
    bit                seen;
    bit                now_locked;
    logic [NUM_CH-1:0] prev_rst;
    int                nd;
    edge_no++;
    lock_pipe.push_back(lk);
    seen = (lock_pipe.size() >= 3) ? lock_pipe[lock_pipe.size()-3] : 1'b0;
    if (lock_pipe.size() > 3) void'(lock_pipe.pop_front());
    prev_rst = m_rst;
    m_lost   = 1'b0;
    if (m_active) begin
      if (!seen) begin
        m_active = 1'b0;
        m_lost   = 1'b1;
        if (m_cnt < 255) m_cnt++;
        m_wd     = 0;
        m_streak = 0;
      end else if (m_t < 1000) begin
        m_t++;
      end
    end else begin
      if (m_wd < TO) begin
        m_wd++;
        if (m_wd == TO) m_to = 1'b1;
      end
      m_streak = seen ? m_streak + 1 : 0;
      if (m_streak == LF + 1) begin
        m_active = 1'b1;
        m_t      = 0;
        m_streak = 0;
      end
    end
    for (int k = 0; k < NUM_CH; k++) m_rst[k] = m_active && (m_t >= k * RS);
    now_locked = m_active && (m_t > (NUM_CH - 1) * RS);
    if (now_locked && !m_locked) m_to = 1'b0;
    m_locked = now_locked;
    for (int k = 0; k < NUM_CH; k++) begin
      nd    = ld ? int'(dv[k*DIV_W +: DIV_W]) : m_shadow[k];
      m_ce[k] = 1'b0;
      if (!prev_rst[k]) begin
        if (m_rst[k]) m_next_ce[k] = edge_no + nd + 1;
      end else if (edge_no == m_next_ce[k]) begin
        m_ce[k]      = m_rst[k];
        m_next_ce[k] = edge_no + nd + 1;
      end
      m_shadow[k] = nd;
    end
  endtask

  task automatic compare_all();
    check("rst_n_o", 32'(rst_n_o), 32'(m_rst));
    check("ce_o", 32'(ce_o), 32'(m_ce));
    check("locked_o", 32'(locked_o), 32'(m_locked));
    check("lock_lost_o", 32'(lock_lost_o), 32'(m_lost));
    check("lost_cnt_o", 32'(lost_cnt_o), 32'(m_cnt));
`ifdef PLL_CLK_MANAGER_LOCK_TIMEOUT_EN
    check("timeout_o", 32'(timeout_o), 32'(m_to));
`endif
  endtask

  // Driver: one clock edge, model update, then compare 1 ns after the edge.
  task automatic step();
    bit                      lk;
    bit                      ld;
    logic [NUM_CH*DIV_W-1:0] dv;
    lk = pll_lock_i;
    ld = div_load_i;
    dv = div_i;
    @(posedge clk);
    if (resetn) model_edge(lk, ld, dv);
    else model_reset();
    #1;
    compare_all();
    if (rst_n_o[0] && rise0 == 0) rise0 = edge_no;
    if (rst_n_o[1] && rise1 == 0) rise1 = edge_no;
    if (locked_o && rise_lk == 0) rise_lk = edge_no;
    if (ce_o[1] && rise_ce1 == 0) rise_ce1 = edge_no;
  endtask

  initial begin
    int hold;
    int drop;
    n_pass     = 0;
    n_total    = 0;
    rise0      = 0;
    rise1      = 0;
    rise_lk    = 0;
    rise_ce1   = 0;
    resetn     = 1'b0;
    pll_lock_i = 1'b1;
    div_i      = '0;
    div_load_i = 1'b0;
    model_reset();

    // Power-up with lock held high; dividers {3,0} loaded before lock is seen.
    repeat (5) step();
    resetn = 1'b1;
    div_i  = {8'd3, 8'd0};
    div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    repeat (34) step();
    check("rst0_rise_edge", 32'(rise0), 32'd19);
    check("rst1_rise_edge", 32'(rise1), 32'd23);
    check("locked_rise_edge", 32'(rise_lk), 32'd24);
    check("ce1_first_edge", 32'(rise_ce1), 32'd27);

    // Runtime change of channel 1 from 3 to 1, one cycle into a period.
    for (int i = 0; i < 10 && !ce_o[1]; i++) step();
    check("ce1_seen", 32'(ce_o[1]), 32'd1);
    step();
    div_i = {8'd1, 8'd0};
    div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    repeat (20) step();

    // Loss of lock in RUN: reaction three edges later.
    pll_lock_i = 1'b0;
    step();
    step();
    check("lost_not_yet", 32'(lock_lost_o), 32'd0);
    step();
    check("lost_pulse", 32'(lock_lost_o), 32'd1);
    check("lost_rst_all_low", 32'(rst_n_o), 32'd0);
    check("lost_cnt_one", 32'(lost_cnt_o), 32'd1);
    step();
    check("lost_pulse_one_cycle", 32'(lock_lost_o), 32'd0);

    // Asynchronous reset while filtering a relock clears the loss counter too.
    pll_lock_i = 1'b1;
    repeat (10) step();
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_lost_cnt", 32'(lost_cnt_o), 32'd0);
    pll_lock_i = 1'b0;
    repeat (3) step();
    resetn = 1'b1;

    // Filter glitch: 10 high, 1 low, then high.
    pll_lock_i = 1'b1;
    repeat (10) step();
    pll_lock_i = 1'b0;
    step();
    pll_lock_i = 1'b1;
    repeat (40) step();
    check("glitch_lost_cnt", 32'(lost_cnt_o), 32'd0);
    check("glitch_locked", 32'(locked_o), 32'd1);

    // Randomized lock drops with random divider reloads; enough losses to saturate.
    for (int i = 0; i < 260; i++) begin
      hold = $urandom_range(24, 40);
      pll_lock_i = 1'b1;
      for (int j = 0; j < hold; j++) begin
        if ($urandom_range(0, 5) == 0) begin
          for (int k = 0; k < NUM_CH; k++) div_i[k*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 5));
          div_load_i = 1'b1;
        end
        step();
        div_load_i = 1'b0;
      end
      drop = $urandom_range(1, 6);
      pll_lock_i = 1'b0;
      repeat (drop) step();
    end
    repeat (4) step();
    check("lost_cnt_saturated", 32'(lost_cnt_o), 32'd255);

`ifdef PLL_CLK_MANAGER_LOCK_TIMEOUT_EN
    // Lock watchdog: no lock for TO cycles, then lock clears the flag on RUN entry.
    resetn = 1'b0;
    pll_lock_i = 1'b0;
    step();
    resetn = 1'b1;
    repeat (99) step();
    check("timeout_before_limit", 32'(timeout_o), 32'd0);
    step();
    check("timeout_at_limit", 32'(timeout_o), 32'd1);
    repeat (20) step();
    check("timeout_sticky", 32'(timeout_o), 32'd1);
    pll_lock_i = 1'b1;
    repeat (30) step();
    check("timeout_locked", 32'(locked_o), 32'd1);
    check("timeout_cleared", 32'(timeout_o), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
